apb_timer: RTL and testbench

//  APB2 peripheral on the low-speed bus downstream of the AHB-to-APB bridge.

---
 rtl/apb_timer_pkg.sv | 26 ++
 rtl/apb_timer_prescaler.sv | 41 ++++
 rtl/apb_timer.sv | 158 +++++++++++++++
 tb/tb_apb_timer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_timer_pkg.sv
// Shared constants for the APB timer: register offsets, CTRL bit positions
// and the APB transfer phase encoding.
package apb_timer_pkg;

  // Byte offsets of the registers within the peripheral window
  localparam int OFF_CTRL   = 'h000;
  localparam int OFF_LOAD   = 'h004;
  localparam int OFF_VALUE  = 'h008;
  localparam int OFF_STATUS = 'h00C;

  // CTRL register bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_RELOAD  = 1;
  localparam int CTRL_IE      = 2;
  localparam int CTRL_PRE_LSB = 8;

  // STATUS register bit positions
  localparam int STATUS_TIF = 0;

  // APB2 transfer phase, derived from PENABLE while PSEL is high
  typedef enum logic {
    SETUP  = 1'b0,
    ACCESS = 1'b1
  } apb_phase_e;

endpackage

// File: rtl/apb_timer_prescaler.sv
// Prescaler for the APB timer: divides the clock by PRESCALE+1 and emits a
// one-cycle tick at the end of each period while enabled.
module apb_timer_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [PRE_W-1:0] prescale_i,
  input  logic             restart_i,
  output logic             tick_o
);

  logic [PRE_W-1:0] cnt_q;
  logic [PRE_W-1:0] cnt_d;

  assign tick_o = en_i & (cnt_q == prescale_i);

  // Next count: held at zero when disabled or restarted, otherwise 0..PRESCALE.
  // Wrapping on >= keeps the count bounded if PRESCALE is lowered mid-period.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || restart_i) begin
      cnt_d = '0;
    end else if (cnt_q >= prescale_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PRE_W'(1);
    end
  end

  // Prescale counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_timer.sv
// APB2 programmable down-counter timer with prescaler, one-shot or
// auto-reload mode and a level interrupt. Zero-wait APB slave: writes commit
// in the access cycle, reads are captured into PRDATA in the setup cycle.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PRE_W = 8,
  parameter int OFF_W = 12
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        IRQ
);

  localparam int WA_W = OFF_W - 2;
  localparam logic [WA_W-1:0] WA_CTRL   = WA_W'(OFF_CTRL   >> 2);
  localparam logic [WA_W-1:0] WA_LOAD   = WA_W'(OFF_LOAD   >> 2);
  localparam logic [WA_W-1:0] WA_VALUE  = WA_W'(OFF_VALUE  >> 2);
  localparam logic [WA_W-1:0] WA_STATUS = WA_W'(OFF_STATUS >> 2);

  // Control/status state
  logic             en_q,     en_d;
  logic             reload_q, reload_d;
  logic             ie_q,     ie_d;
  logic [PRE_W-1:0] pre_q,    pre_d;
  logic [CNT_W-1:0] load_q,   load_d;
  logic [CNT_W-1:0] value_q,  value_d;
  logic             tif_q,    tif_d;
  logic [31:0]      prdata_q, prdata_d;

  apb_phase_e       phase;
  logic [WA_W-1:0]  word_addr;
  logic             wr_commit, rd_setup;
  logic             wr_ctrl, wr_load, wr_status;
  logic             tick, expire;
  logic [31:0]      rdata;

  // Address bits outside the decoded window and unused write-data bits
  logic unused_bits;
  assign unused_bits = ^{PADDR[31:OFF_W], PADDR[1:0], PWDATA};

  // APB decode: phase, word offset and per-register write strobes
  always_comb begin
    phase     = PENABLE ? ACCESS : SETUP;
    word_addr = PADDR[OFF_W-1:2];
    wr_commit = PSEL & (phase == ACCESS) & PWRITE;
    rd_setup  = PSEL & (phase == SETUP) & ~PWRITE;
    wr_ctrl   = wr_commit & (word_addr == WA_CTRL);
    wr_load   = wr_commit & (word_addr == WA_LOAD);
    wr_status = wr_commit & (word_addr == WA_STATUS);
  end

  apb_timer_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk_i      (HCLK),
    .rst_i      (HRESET),
    .en_i       (en_q),
    .prescale_i (pre_q),
    .restart_i  (wr_load),
    .tick_o     (tick)
  );

  // A LOAD write consumes a coincident tick entirely, so it cannot expire
  assign expire = tick & ~wr_load & (value_q == '0);

  // Next-state for registers and counter; bus writes take priority over
  // the counter except that a timer expiry always sets TIF
  always_comb begin
    en_d     = en_q;
    reload_d = reload_q;
    ie_d     = ie_q;
    pre_d    = pre_q;
    load_d   = load_q;
    value_d  = value_q;
    tif_d    = tif_q;

    if (expire && !reload_q) begin
      en_d = 1'b0;
    end
    if (wr_ctrl) begin
      en_d     = PWDATA[CTRL_EN];
      reload_d = PWDATA[CTRL_RELOAD];
      ie_d     = PWDATA[CTRL_IE];
      pre_d    = PWDATA[CTRL_PRE_LSB +: PRE_W];
    end

    if (wr_load) begin
      load_d  = PWDATA[CNT_W-1:0];
      value_d = PWDATA[CNT_W-1:0];
    end else if (tick) begin
      if (value_q != '0) begin
        value_d = value_q - CNT_W'(1);
      end else if (reload_q) begin
        value_d = load_q;
      end
    end

    if (wr_status && PWDATA[STATUS_TIF]) begin
      tif_d = 1'b0;
    end
    if (expire) begin
      tif_d = 1'b1;
    end
  end

  // Read multiplexer; unmapped offsets and unused bits read as zero
  always_comb begin
    rdata = '0;
    if (word_addr == WA_CTRL) begin
      rdata[CTRL_EN]                 = en_q;
      rdata[CTRL_RELOAD]             = reload_q;
      rdata[CTRL_IE]                 = ie_q;
      rdata[CTRL_PRE_LSB +: PRE_W]   = pre_q;
    end else if (word_addr == WA_LOAD) begin
      rdata[CNT_W-1:0] = load_q;
    end else if (word_addr == WA_VALUE) begin
      rdata[CNT_W-1:0] = value_q;
    end else if (word_addr == WA_STATUS) begin
      rdata[STATUS_TIF] = tif_q;
    end
    prdata_d = rd_setup ? rdata : prdata_q;
  end

  // State registers; reset drops any transfer in flight
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      en_q     <= 1'b0;
      reload_q <= 1'b0;
      ie_q     <= 1'b0;
      pre_q    <= '0;
      load_q   <= '0;
      value_q  <= '0;
      tif_q    <= 1'b0;
      prdata_q <= '0;
    end else begin
      en_q     <= en_d;
      reload_q <= reload_d;
      ie_q     <= ie_d;
      pre_q    <= pre_d;
      load_q   <= load_d;
      value_q  <= value_d;
      tif_q    <= tif_d;
      prdata_q <= prdata_d;
    end
  end

  assign PRDATA = prdata_q;
  assign IRQ    = tif_q & ie_q;

endmodule

// File: tb/tb_apb_timer.sv
// Directed bench for apb_timer: a back-to-back table of APB transfers with
// hand-computed read data and IRQ, followed by read-after-write, PRDATA hold
// and reset-during-transfer sequences.
module tb_apb_timer;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA;
  logic        IRQ;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    bit          irq;
  } vec_t;

  vec_t vq[$];

  apb_timer dut (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .IRQ     (IRQ)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One APB transfer starting at a negedge; returns PRDATA sampled in the
  // access cycle and after it. Ends at a negedge with the bus idle.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      output logic [31:0] rd_acc, output logic [31:0] rd_end);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(posedge HCLK); @(negedge HCLK);
    PENABLE = 1'b1;
    rd_acc = PRDATA;
    @(posedge HCLK); @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    rd_end = PRDATA;
  endtask

  task automatic v(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                   input logic [31:0] exp, input bit irq);
    vec_t t;
    t.wr = wr; t.addr = addr; t.data = data; t.exp = exp; t.irq = irq;
    vq.push_back(t);
  endtask

  initial begin
    logic [31:0] r1, r2;

    // Transfer i sets up at edge 2i+1 and commits at edge 2i+2 after reset.
    // Reset state of every offset, including an unmapped one
    v(0, 32'h000, 0, 32'h0, 0);
    v(0, 32'h004, 0, 32'h0, 0);
    v(0, 32'h008, 0, 32'h0, 0);
    v(0, 32'h00C, 0, 32'h0, 0);
    v(0, 32'h010, 0, 32'h0, 0);
    // One-shot, PRESCALE=0: VALUE 5 at edge14, expiry at edge 20
    v(1, 32'h004, 32'h5, 0, 0);
    v(1, 32'h000, 32'h5, 0, 0);
    v(0, 32'h008, 0, 32'h5, 0);
    v(0, 32'h008, 0, 32'h3, 0);
    v(0, 32'h008, 0, 32'h1, 1);
    v(0, 32'h008, 0, 32'h0, 1);
    v(0, 32'h000, 0, 32'h4, 1);
    v(0, 32'h00C, 0, 32'h1, 1);
    v(1, 32'h00C, 32'h1, 0, 0);
    v(0, 32'h00C, 0, 32'h0, 0);
    // VALUE is read-only, unmapped writes ignored, CTRL unused bits read 0
    v(1, 32'h008, 32'h1234, 0, 0);
    v(0, 32'h008, 0, 32'h0, 0);
    v(1, 32'h010, 32'hFFFF_FFFF, 0, 0);
    v(0, 32'h010, 0, 32'h0, 0);
    v(1, 32'h000, 32'hFFFF_FFFE, 0, 0);
    v(0, 32'h000, 0, 32'h0000_FF06, 0);
    v(1, 32'h000, 32'h0, 0, 0);
    // Upper address bits and byte lane bits ignored
    v(0, 32'hABCD_F004, 0, 32'h5, 0);
    v(0, 32'h007, 0, 32'h5, 0);
    // Auto-reload LOAD=2, PRESCALE=3: ticks at edges 56,60,...; expiries 64,76,88
    v(1, 32'h004, 32'h2, 0, 0);
    v(1, 32'h000, 32'h0303, 0, 0);
    v(0, 32'h008, 0, 32'h2, 0);
    v(0, 32'h008, 0, 32'h2, 0);
    v(0, 32'h008, 0, 32'h1, 0);
    v(0, 32'h008, 0, 32'h1, 0);
    v(0, 32'h008, 0, 32'h0, 0);
    v(0, 32'h00C, 0, 32'h0, 0);
    v(0, 32'h00C, 0, 32'h1, 0);
    v(1, 32'h00C, 32'h1, 0, 0);
    v(0, 32'h00C, 0, 32'h0, 0);
    v(0, 32'h008, 0, 32'h1, 0);
    v(0, 32'h00C, 0, 32'h0, 0);
    v(0, 32'h00C, 0, 32'h0, 0);
    v(0, 32'h00C, 0, 32'h1, 0);
    // Clear TIF, then W1C lands on the expiry at edge 88: TIF stays set
    v(1, 32'h00C, 32'h1, 0, 0);
    v(0, 32'h00C, 0, 32'h0, 0);
    v(0, 32'h008, 0, 32'h1, 0);
    v(0, 32'h00C, 0, 32'h0, 0);
    v(1, 32'h00C, 32'h1, 0, 0);
    v(0, 32'h00C, 0, 32'h1, 0);
    // LOAD=9 lands on the tick at edge 92: no decrement
    v(1, 32'h004, 32'h9, 0, 0);
    v(0, 32'h008, 0, 32'h9, 0);
    v(0, 32'h008, 0, 32'h9, 0);
    v(0, 32'h008, 0, 32'h8, 0);
    v(0, 32'h00C, 0, 32'h1, 0);
    // LOAD=3 mid-period at edge 102 restarts the prescaler: next tick at 106
    v(1, 32'h004, 32'h3, 0, 0);
    v(0, 32'h008, 0, 32'h3, 0);
    v(0, 32'h008, 0, 32'h3, 0);
    v(0, 32'h008, 0, 32'h2, 0);
    // One-shot auto-clear of EN at edge 118 coincides with a CTRL write
    v(1, 32'h000, 32'h0, 0, 0);
    v(1, 32'h00C, 32'h1, 0, 0);
    v(1, 32'h004, 32'h1, 0, 0);
    v(1, 32'h000, 32'h1, 0, 0);
    v(1, 32'h000, 32'h5, 0, 1);
    v(0, 32'h000, 0, 32'h5, 1);
    v(0, 32'h000, 0, 32'h4, 1);
    v(0, 32'h00C, 0, 32'h1, 1);

    HRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    check("reset prdata", PRDATA, 32'h0);
    check("reset irq", {31'b0, IRQ}, 32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      xfer(vq[i].wr, vq[i].addr, vq[i].data, r1, r2);
      if (!vq[i].wr) begin
        check($sformatf("vec%0d rdata access", i), r1, vq[i].exp);
        check($sformatf("vec%0d rdata hold", i), r2, vq[i].exp);
      end
      check($sformatf("vec%0d irq", i), {31'b0, IRQ}, {31'b0, vq[i].irq});
    end

    // Read immediately after write returns the written value and holds
    xfer(1, 32'h004, 32'h77, r1, r2);
    xfer(0, 32'h004, 0, r1, r2);
    check("raw access", r1, 32'h77);
    check("raw end", r2, 32'h77);
    repeat (3) @(negedge HCLK);
    check("prdata idle hold", PRDATA, 32'h77);
    xfer(1, 32'h000, 32'h0307, r1, r2);
    check("prdata hold across write", r2, 32'h77);
    check("irq before reset", {31'b0, IRQ}, 32'h1);
    repeat (5) @(negedge HCLK);

    // Reset asserted in the access cycle of a LOAD write
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h004; PWDATA = 32'hDEAD;
    @(posedge HCLK); @(negedge HCLK);
    PENABLE = 1'b1; HRESET = 1'b1;
    @(posedge HCLK); @(negedge HCLK);
    HRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    check("post-reset irq", {31'b0, IRQ}, 32'h0);
    check("post-reset prdata", PRDATA, 32'h0);
    for (int a = 0; a < 4; a++) begin
      xfer(0, 32'(a * 4), 0, r1, r2);
      check($sformatf("post-reset read %0h", a * 4), r1, 32'h0);
    end
    repeat (10) @(negedge HCLK);
    xfer(0, 32'h008, 0, r1, r2);
    check("post-reset value idle", r1, 32'h0);
    check("post-reset irq idle", {31'b0, IRQ}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
